// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared constants, types and helpers for the PWM DAC output stage.
//   WIDTH          : default sample width; the PWM period is 2^WIDTH-1 cycles
//   PERIOD_LAST    : last counter value of a period (2^WIDTH-2)
//   UNDERRUN_CNT_W : width of the saturating underrun counter
//   buf_action_e   : what the sample buffer does on a given clock edge
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int WIDTH          = 8;
    localparam int PERIOD_LAST    = (1 << WIDTH) - 2;
    localparam int UNDERRUN_CNT_W = 8;

    // Buffer/duty update selected each cycle. The order of the checks in
    // decode_action gives the priority between overlapping conditions.
    typedef enum logic [2:0] {
        ACT_HOLD        = 3'd0,  // nothing happens
        ACT_STORE       = 3'd1,  // mid-period accept into the pending slot
        ACT_LOAD_PEND   = 3'd2,  // boundary: pending sample becomes duty
        ACT_LOAD_REFILL = 3'd3,  // boundary: pending -> duty, new sample -> pending
        ACT_BYPASS      = 3'd4,  // boundary, empty slot: new sample straight to duty
        ACT_UNDERRUN    = 3'd5   // boundary with nothing to play next
    } buf_action_e;

    function automatic buf_action_e decode_action(
        input logic last,
        input logic pend_full,
        input logic fire
    );
        if (last && pend_full) begin
            return fire ? ACT_LOAD_REFILL : ACT_LOAD_PEND;
        end else if (last && fire) begin
            return ACT_BYPASS;
        end else if (last) begin
            return ACT_UNDERRUN;
        end else if (fire) begin
            return ACT_STORE;
        end
        return ACT_HOLD;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
        input logic [UNDERRUN_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pwm_dac_out_if.sv
// -----------------------------------------------------------------------------
// pwm_dac_out_if
// Sample stream from the function generator into the PWM DAC.
//   in_data  : unsigned sample
//   in_valid : in_data is valid this cycle
//   in_ready : sink accepts in_data this cycle (transfer = in_valid & in_ready)
// Modports: master = sample producer, slave = the DAC.
// -----------------------------------------------------------------------------
interface pwm_dac_out_if #(
    parameter int WIDTH = dac_pkg::WIDTH
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
// Free-running PWM phase counter, 0 .. 2^WIDTH-2, one period = 2^WIDTH-1 cycles.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   en   : run enable; while low the counter is forced to 0
//   cnt  : current phase
//   last : high in the final cycle of an enabled period (combinational)
// -----------------------------------------------------------------------------
module pwm_period_counter
    import dac_pkg::*;
#(
    parameter int WIDTH = dac_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'((1 << WIDTH) - 2);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Disabling clears the phase, so re-enabling always starts a fresh period.
    always_comb begin
        last  = en && (cnt_q == LAST_VAL);
        cnt_d = '0;
        if (en && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_dac_out.sv
// -----------------------------------------------------------------------------
// pwm_dac_out
// PWM output stage: accepts WIDTH-bit unsigned samples over a valid/ready
// stream, holds one sample in a single-entry buffer and plays each sample as
// one (2^WIDTH-1)-cycle PWM period on pwm_out (k high cycles for sample k).
// A period boundary with no sample available repeats the previous duty and
// reports an underrun.
//   clk          : system clock
//   rst          : synchronous active-low reset
//   en           : run enable; low freezes the counter at 0 and drives pin low
//   in_if        : sample stream (slave side)
//   pwm_out      : registered PWM pin
//   period_start : registered pulse on the first pin cycle of each period
//   underrun     : registered pulse when a boundary finds no sample
//   underrun_cnt : saturating underrun count
// -----------------------------------------------------------------------------
module pwm_dac_out
    import dac_pkg::*;
#(
    parameter int WIDTH = dac_pkg::WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    pwm_dac_out_if.slave              in_if,
    output logic                      pwm_out,
    output logic                      period_start,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

    logic [WIDTH-1:0] cnt;
    logic             last;
    logic             in_ready;
    logic             fire;
    buf_action_e      action;

    logic [WIDTH-1:0]          duty_q,         duty_d;
    logic [WIDTH-1:0]          pend_data_q,    pend_data_d;
    logic                      pend_full_q,    pend_full_d;
    logic                      pwm_out_q,      pwm_out_d;
    logic                      period_start_q, period_start_d;
    logic                      underrun_q,     underrun_d;
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt),
        .last (last)
    );

    // A full slot still takes a new sample in the last cycle, because the
    // slot empties into duty on that same edge.
    assign in_ready       = ~pend_full_q | last;
    assign in_if.in_ready = in_ready;
    assign fire           = in_if.in_valid & in_ready;

    always_comb begin
        duty_d         = duty_q;
        pend_data_d    = pend_data_q;
        pend_full_d    = pend_full_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        action         = decode_action(last, pend_full_q, fire);

        case (action)
            ACT_STORE: begin
                pend_data_d = in_if.in_data;
                pend_full_d = 1'b1;
            end
            ACT_LOAD_PEND: begin
                duty_d      = pend_data_q;
                pend_full_d = 1'b0;
            end
            ACT_LOAD_REFILL: begin
                duty_d      = pend_data_q;
                pend_data_d = in_if.in_data;
            end
            ACT_BYPASS: begin
                duty_d = in_if.in_data;
            end
            ACT_UNDERRUN: begin
                underrun_d     = 1'b1;
                underrun_cnt_d = sat_inc(underrun_cnt_q);
            end
            default: begin
            end
        endcase

        // Strict compare: duty 0 never goes high, full-scale stays high all
        // 2^WIDTH-1 cycles since cnt never reaches 2^WIDTH-1.
        pwm_out_d      = en & (cnt < duty_q);
        period_start_d = en & (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_q         <= '0;
            pend_data_q    <= '0;
            pend_full_q    <= 1'b0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            duty_q         <= duty_d;
            pend_data_q    <= pend_data_d;
            pend_full_q    <= pend_full_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule
